// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file command initiator.
// Default sizes, command op encodings and FSM state type.
package regfile_pkg;

    localparam int WIDTH_DEF  = 4;
    localparam int ADDR_W_DEF = 3;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b10;
    localparam logic [1:0] OP_RSV   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        WB   = 2'b10,
        RESP = 2'b11
    } state_t;

endpackage

// File: rtl/regfile_initiator.sv
// Command-driven initiator for an async-read / sync-write register file.
// One command in flight: latch, execute, optional write-back, respond.
module regfile_initiator
    import regfile_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_rd,
    input  logic [ADDR_W-1:0] cmd_rs1,
    input  logic [ADDR_W-1:0] cmd_rs2,
    input  logic [WIDTH-1:0]  cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WIDTH-1:0]  rsp_data1,
    output logic [WIDTH-1:0]  rsp_data2,
    output logic              rsp_carry,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] rf_read_reg1,
    output logic [ADDR_W-1:0] rf_read_reg2,
    input  logic [WIDTH-1:0]  rf_read_data1,
    input  logic [WIDTH-1:0]  rf_read_data2,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_write_reg,
    output logic [WIDTH-1:0]  rf_write_data
);

    state_t              r_state;
    state_t              w_next;

    logic [1:0]          r_op;
    logic [ADDR_W-1:0]   r_rd;
    logic [ADDR_W-1:0]   r_rs1;
    logic [ADDR_W-1:0]   r_rs2;
    logic [WIDTH-1:0]    r_data;

    logic                r_rsp_valid;
    logic [WIDTH-1:0]    r_d1;
    logic [WIDTH-1:0]    r_d2;
    logic                r_carry;
    logic                r_err;

    logic                w_err;
    logic                w_accept;
    logic                w_rsp_fire;
    logic [WIDTH-1:0]    w_rd1;
    logic [WIDTH-1:0]    w_rd2;
    logic [WIDTH:0]      w_sum;

    assign w_accept   = (r_state == IDLE) && cmd_valid;
    assign w_rsp_fire = (r_state == RESP) && r_rsp_valid && rsp_ready;

    assign w_err = (r_op == OP_RSV) ||
                   (((r_op == OP_WRITE) || (r_op == OP_ADD)) &&
                    (r_rd == '0));

    // entry 0 always reads as zero regardless of the attached file
    assign w_rd1 = (r_rs1 == '0) ? '0 : rf_read_data1;
    assign w_rd2 = (r_rs2 == '0) ? '0 : rf_read_data2;
    assign w_sum = {1'b0, w_rd1} + {1'b0, r_data};

    // response fields are forced to zero while no response is offered
    assign rsp_valid = r_rsp_valid;
    assign rsp_data1 = r_rsp_valid ? r_d1    : '0;
    assign rsp_data2 = r_rsp_valid ? r_d2    : '0;
    assign rsp_carry = r_rsp_valid ? r_carry : 1'b0;
    assign rsp_err   = r_rsp_valid ? r_err   : 1'b0;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // next state and register-file port drive
    always_comb begin
        w_next        = r_state;
        cmd_ready     = 1'b0;
        rf_we         = 1'b0;
        rf_write_reg  = '0;
        rf_write_data = '0;
        rf_read_reg1  = '0;
        rf_read_reg2  = '0;
        unique case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_next = EXEC;
                end
            end
            EXEC: begin
                rf_read_reg1 = r_rs1;
                rf_read_reg2 = r_rs2;
                if ((r_op == OP_WRITE) && !w_err) begin
                    rf_we         = 1'b1;
                    rf_write_reg  = r_rd;
                    rf_write_data = r_data;
                end
                w_next = (r_op == OP_ADD) ? WB : RESP;
            end
            WB: begin
                if (!w_err) begin
                    rf_we         = 1'b1;
                    rf_write_reg  = r_rd;
                    rf_write_data = r_d1;
                end
                w_next = RESP;
            end
            RESP: begin
                if (r_rsp_valid && rsp_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // latch the whole command on acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op   <= OP_WRITE;
            r_rd   <= '0;
            r_rs1  <= '0;
            r_rs2  <= '0;
            r_data <= '0;
        end else if (w_accept) begin
            r_op   <= cmd_op;
            r_rd   <= cmd_rd;
            r_rs1  <= cmd_rs1;
            r_rs2  <= cmd_rs2;
            r_data <= cmd_data;
        end
    end

    // capture results at the end of EXEC; they hold through RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d1    <= '0;
            r_d2    <= '0;
            r_carry <= 1'b0;
            r_err   <= 1'b0;
        end else if (r_state == EXEC) begin
            r_err <= w_err;
            unique case (r_op)
                OP_WRITE: begin
                    r_d1    <= r_data;
                    r_d2    <= '0;
                    r_carry <= 1'b0;
                end
                OP_READ: begin
                    r_d1    <= w_rd1;
                    r_d2    <= w_rd2;
                    r_carry <= 1'b0;
                end
                OP_ADD: begin
                    r_d1    <= w_sum[WIDTH-1:0];
                    r_d2    <= '0;
                    r_carry <= w_sum[WIDTH];
                end
                default: begin
                    r_d1    <= '0;
                    r_d2    <= '0;
                    r_carry <= 1'b0;
                end
            endcase
        end else if (w_rsp_fire) begin
            r_d1    <= '0;
            r_d2    <= '0;
            r_carry <= 1'b0;
            r_err   <= 1'b0;
        end
    end

    // response is offered from the second RESP cycle until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
        end else if (r_state == RESP) begin
            r_rsp_valid <= !(r_rsp_valid && rsp_ready);
        end else begin
            r_rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_initiator.sv
// Directed bench for regfile_initiator with a behavioural register file.
// Vector table for single commands plus backpressure and reset sequences.
module tb_regfile_initiator;
    import regfile_pkg::*;

    localparam int W = 4;
    localparam int A = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_op = 2'b00;
    logic [A-1:0] cmd_rd = '0;
    logic [A-1:0] cmd_rs1 = '0;
    logic [A-1:0] cmd_rs2 = '0;
    logic [W-1:0] cmd_data = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_data1;
    logic [W-1:0] rsp_data2;
    logic         rsp_carry;
    logic         rsp_err;
    logic [A-1:0] rf_read_reg1;
    logic [A-1:0] rf_read_reg2;
    logic [W-1:0] rf_read_data1;
    logic [W-1:0] rf_read_data2;
    logic         rf_we;
    logic [A-1:0] rf_write_reg;
    logic [W-1:0] rf_write_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_initiator #(.WIDTH(W), .ADDR_W(A)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rd(cmd_rd),
        .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
        .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data1(rsp_data1), .rsp_data2(rsp_data2),
        .rsp_carry(rsp_carry), .rsp_err(rsp_err),
        .rf_read_reg1(rf_read_reg1), .rf_read_reg2(rf_read_reg2),
        .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
        .rf_we(rf_we), .rf_write_reg(rf_write_reg),
        .rf_write_data(rf_write_data)
    );

    // behavioural register file: async read, sync write, entry 0 zero
    logic [W-1:0] rf [8] = '{default: '0};
    assign rf_read_data1 = (rf_read_reg1 == '0) ? '0 : rf[rf_read_reg1];
    assign rf_read_data2 = (rf_read_reg2 == '0) ? '0 : rf[rf_read_reg2];
    always @(posedge clk) begin
        if (rf_we && rf_write_reg != '0) rf[rf_write_reg] <= rf_write_data;
    end

    // write-port monitor, sampled mid-cycle
    int           we_cnt = 0;
    logic [A-1:0] we_addr = '0;
    logic [W-1:0] we_data = '0;
    always @(negedge clk) begin
        if (rf_we) begin
            we_cnt  = we_cnt + 1;
            we_addr = rf_write_reg;
            we_data = rf_write_data;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0]   op;
        logic [A-1:0] rd;
        logic [A-1:0] rs1;
        logic [A-1:0] rs2;
        logic [W-1:0] data;
        logic [W-1:0] d1;
        logic [W-1:0] d2;
        logic         c;
        logic         err;
        int           lat;
        logic         we;
        logic [A-1:0] wa;
        logic [W-1:0] wd;
    } vec_t;

    task automatic run_vec(input vec_t t, input string tag);
        int cyc;
        int w0;
        cmd_valid = 1'b1;
        cmd_op    = t.op;
        cmd_rd    = t.rd;
        cmd_rs1   = t.rs1;
        cmd_rs2   = t.rs2;
        cmd_data  = t.data;
        chk({tag, " ready"}, 32'(cmd_ready), 32'd1);
        w0 = we_cnt;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_rd    = '0;
        cmd_rs1   = '0;
        cmd_rs2   = '0;
        cmd_data  = '0;
        chk({tag, " busy"}, 32'(cmd_ready), 32'd0);
        chk({tag, " rsp zero"},
            32'({rsp_valid, rsp_data1, rsp_data2, rsp_carry, rsp_err}), 32'd0);
        cyc = 0;
        while (!rsp_valid && cyc < 8) begin
            tick();
            cyc++;
        end
        chk({tag, " latency"}, 32'(cyc), 32'(t.lat));
        chk({tag, " d1"}, 32'(rsp_data1), 32'(t.d1));
        chk({tag, " d2"}, 32'(rsp_data2), 32'(t.d2));
        chk({tag, " carry"}, 32'(rsp_carry), 32'(t.c));
        chk({tag, " err"}, 32'(rsp_err), 32'(t.err));
        chk({tag, " we count"}, 32'(we_cnt - w0), t.we ? 32'd1 : 32'd0);
        if (t.we) begin
            chk({tag, " waddr"}, 32'(we_addr), 32'(t.wa));
            chk({tag, " wdata"}, 32'(we_data), 32'(t.wd));
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({tag, " rsp done"}, 32'(rsp_valid), 32'd0);
        chk({tag, " ready again"}, 32'(cmd_ready), 32'd1);
    endtask

    vec_t v[10];
    vec_t t;
    int   w0;

    initial begin
        v[0] = '{OP_WRITE, 3'd3, 3'd0, 3'd0, 4'hA, 4'hA, 4'h0, 1'b0, 1'b0, 2, 1'b1, 3'd3, 4'hA};
        v[1] = '{OP_READ,  3'd0, 3'd3, 3'd0, 4'h0, 4'hA, 4'h0, 1'b0, 1'b0, 2, 1'b0, 3'd0, 4'h0};
        v[2] = '{OP_ADD,   3'd3, 3'd3, 3'd0, 4'h9, 4'h3, 4'h0, 1'b1, 1'b0, 3, 1'b1, 3'd3, 4'h3};
        v[3] = '{OP_WRITE, 3'd0, 3'd0, 3'd0, 4'hF, 4'hF, 4'h0, 1'b0, 1'b1, 2, 1'b0, 3'd0, 4'h0};
        v[4] = '{OP_RSV,   3'd2, 3'd3, 3'd3, 4'h6, 4'h0, 4'h0, 1'b0, 1'b1, 2, 1'b0, 3'd0, 4'h0};
        v[5] = '{OP_WRITE, 3'd5, 3'd0, 3'd0, 4'h7, 4'h7, 4'h0, 1'b0, 1'b0, 2, 1'b1, 3'd5, 4'h7};
        v[6] = '{OP_READ,  3'd0, 3'd5, 3'd3, 4'h0, 4'h7, 4'h3, 1'b0, 1'b0, 2, 1'b0, 3'd0, 4'h0};
        v[7] = '{OP_ADD,   3'd0, 3'd5, 3'd0, 4'h2, 4'h9, 4'h0, 1'b0, 1'b1, 3, 1'b0, 3'd0, 4'h0};
        v[8] = '{OP_ADD,   3'd6, 3'd0, 3'd0, 4'hF, 4'hF, 4'h0, 1'b0, 1'b0, 3, 1'b1, 3'd6, 4'hF};
        v[9] = '{OP_READ,  3'd0, 3'd6, 3'd5, 4'h0, 4'hF, 4'h7, 1'b0, 1'b0, 2, 1'b0, 3'd0, 4'h0};

        #2;
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rf_we", 32'(rf_we), 32'd0);
        chk("reset rsp fields",
            32'({rsp_data1, rsp_data2, rsp_carry, rsp_err}), 32'd0);
        chk("reset rf ports",
            32'({rf_read_reg1, rf_read_reg2, rf_write_reg, rf_write_data}), 32'd0);
        chk("reset cmd_ready", 32'(cmd_ready), 32'd1);
        tick();
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_vec(v[i], $sformatf("v%0d", i));
        end

        // backpressure: response held, new command ignored until taken
        cmd_valid = 1'b1;
        cmd_op    = OP_READ;
        cmd_rs1   = 3'd5;
        cmd_rs2   = 3'd3;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 8 && !rsp_valid; i++) tick();
        chk("bp first valid", 32'(rsp_valid), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = OP_WRITE;
        cmd_rd    = 3'd7;
        cmd_rs1   = 3'd0;
        cmd_rs2   = 3'd0;
        cmd_data  = 4'h5;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("bp hold valid %0d", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp hold data %0d", i),
                32'({rsp_data1, rsp_data2, rsp_carry, rsp_err}),
                32'({4'h7, 4'h3, 1'b0, 1'b0}));
            chk($sformatf("bp hold ready %0d", i), 32'(cmd_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("bp after hs valid", 32'(rsp_valid), 32'd0);
        chk("bp after hs ready", 32'(cmd_ready), 32'd1);
        w0 = we_cnt;
        tick();
        cmd_valid = 1'b0;
        chk("bp next accepted", 32'(cmd_ready), 32'd0);
        tick();
        tick();
        chk("bp next valid", 32'(rsp_valid), 32'd1);
        chk("bp next d1", 32'(rsp_data1), 32'h5);
        chk("bp next we", 32'(we_cnt - w0), 32'd1);
        chk("bp next waddr", 32'(we_addr), 32'd7);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // reset during ADD write-back aborts the command
        cmd_valid = 1'b1;
        cmd_op    = OP_ADD;
        cmd_rd    = 3'd4;
        cmd_rs1   = 3'd5;
        cmd_rs2   = 3'd0;
        cmd_data  = 4'h1;
        w0 = we_cnt;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("rst wb we", 32'(rf_we), 32'd1);
        chk("rst wb addr", 32'(rf_write_reg), 32'd4);
        rst_n = 1'b0;
        #1;
        chk("rst drop we", 32'(rf_we), 32'd0);
        chk("rst drop ports", 32'({rf_write_reg, rf_write_data}), 32'd0);
        chk("rst no rsp", 32'(rsp_valid), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst release ready", 32'(cmd_ready), 32'd1);
        chk("rst release rsp", 32'(rsp_valid), 32'd0);
        chk("rst no write", 32'(we_cnt - w0), 32'd0);

        t = '{OP_READ, 3'd0, 3'd4, 3'd7, 4'h0, 4'h0, 4'h5, 1'b0, 1'b0, 2, 1'b0, 3'd0, 4'h0};
        run_vec(t, "post rst read");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
